// File: rtl/fp32_compare.sv
// IEEE-754 binary32 order comparator with registered gt/eq/lt/unordered flags.
// Zeros compare equal regardless of sign; subnormals are compared exactly.
module fp32_compare (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic        a_gt_b,
   output logic        a_eq_b,
   output logic        a_lt_b,
   output logic        unordered
);

   logic       w_a_sign;
   logic       w_b_sign;
   logic [7:0] w_a_exp;
   logic [7:0] w_b_exp;
   logic [22:0] w_a_frac;
   logic [22:0] w_b_frac;
   logic [30:0] w_a_mag;
   logic [30:0] w_b_mag;

   assign w_a_sign = a[31];
   assign w_b_sign = b[31];
   assign w_a_exp  = a[30:23];
   assign w_b_exp  = b[30:23];
   assign w_a_frac = a[22:0];
   assign w_b_frac = b[22:0];
   assign w_a_mag  = a[30:0];
   assign w_b_mag  = b[30:0];

   logic w_a_nan;
   logic w_b_nan;
   logic w_a_zero;
   logic w_b_zero;

   assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
   assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
   assign w_a_zero = ~|w_a_mag;
   assign w_b_zero = ~|w_b_mag;

   // Biased exponent sits above the fraction, so the raw magnitude
   // field orders correctly as an unsigned integer, Inf included.
   logic w_mag_gt;
   logic w_mag_eq;

   assign w_mag_gt = w_a_mag > w_b_mag;
   assign w_mag_eq = w_a_mag == w_b_mag;

   logic w_gt;
   logic w_eq;
   logic w_lt;
   logic w_un;

   always_comb begin
      w_gt = 1'b0;
      w_eq = 1'b0;
      w_lt = 1'b0;
      w_un = 1'b0;
      if (w_a_nan || w_b_nan) begin
         w_un = 1'b1;
      end else if (w_a_zero && w_b_zero) begin
         w_eq = 1'b1;
      end else if (w_a_sign != w_b_sign) begin
         w_gt = ~w_a_sign;
         w_lt = w_a_sign;
      end else if (w_mag_eq) begin
         w_eq = 1'b1;
      end else if (!w_a_sign) begin
         w_gt = w_mag_gt;
         w_lt = ~w_mag_gt;
      end else begin
         w_gt = ~w_mag_gt;
         w_lt = w_mag_gt;
      end
   end

   logic r_valid;
   logic r_gt;
   logic r_eq;
   logic r_lt;
   logic r_un;

   // Flags only load on accepted operands so idle cycles leave them stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
         r_un    <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_gt <= w_gt;
            r_eq <= w_eq;
            r_lt <= w_lt;
            r_un <= w_un;
         end
      end
   end

   assign out_valid = r_valid;
   assign a_gt_b    = r_gt;
   assign a_eq_b    = r_eq;
   assign a_lt_b    = r_lt;
   assign unordered = r_un;

endmodule

// File: tb/tb_fp32_compare.sv
// Directed and randomized checks for fp32_compare.
// Reference ordering uses a monotonic integer key per operand.
module tb_fp32_compare;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        a_gt_b;
   logic        a_eq_b;
   logic        a_lt_b;
   logic        unordered;

   int checks;
   int failures;

   fp32_compare dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .a_gt_b    (a_gt_b),
      .a_eq_b    (a_eq_b),
      .a_lt_b    (a_lt_b),
      .unordered (unordered)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {gt, eq, lt, unordered}
   localparam logic [3:0] GT = 4'b1000;
   localparam logic [3:0] EQ = 4'b0100;
   localparam logic [3:0] LT = 4'b0010;
   localparam logic [3:0] UN = 4'b0001;

   function automatic logic [31:0] key(input logic [31:0] x);
      if (x[30:0] == 31'd0) return 32'h8000_0000;
      if (x[31]) return ~x;
      return x | 32'h8000_0000;
   endfunction

   function automatic logic [3:0] ref_cmp(input logic [31:0] x,
                                          input logic [31:0] y);
      logic [31:0] kx;
      logic [31:0] ky;
      if ((x[30:23] == 8'hFF && x[22:0] != 0) ||
          (y[30:23] == 8'hFF && y[22:0] != 0))
         return UN;
      kx = key(x);
      ky = key(y);
      if (kx > ky) return GT;
      if (kx < ky) return LT;
      return EQ;
   endfunction

   function automatic logic [3:0] flags();
      return {a_gt_b, a_eq_b, a_lt_b, unordered};
   endfunction

   // Drive one pair at posedge+1, advance one edge, sample at posedge+1.
   task automatic step(input logic v, input logic [31:0] x,
                       input logic [31:0] y);
      in_valid = v;
      a = x;
      b = y;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = 32'd0;
      b = 32'd0;
      #12;
      checks++;
      if ({out_valid, flags()} !== 5'b0) begin
         failures++;
         $display("FAIL reset_init got=%b want=00000", {out_valid, flags()});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 32'h4000_0000, 32'h3F80_0000);
      checks++;
      if ({out_valid, flags()} !== {1'b1, GT}) begin
         failures++;
         $display("FAIL reset_pre got=%b want=%b", {out_valid, flags()},
                  {1'b1, GT});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, flags()} !== 5'b0) begin
         failures++;
         $display("FAIL reset_async got=%b want=00000", {out_valid, flags()});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 32'h3F80_0000, 32'h4000_0000);
      checks++;
      if ({out_valid, flags()} !== {1'b1, LT}) begin
         failures++;
         $display("FAIL reset_first got=%b want=%b", {out_valid, flags()},
                  {1'b1, LT});
      end
   endtask

   task automatic test_sign();
      logic [31:0] va [3] = '{32'hC000_0000, 32'h3F80_0000, 32'h4120_0000};
      logic [31:0] vb [3] = '{32'hBF80_0000, 32'hBF80_0000, 32'h4120_0000};
      logic [3:0]  ve [3] = '{LT, GT, EQ};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, va[i], vb[i]);
         checks++;
         if ({out_valid, flags()} !== {1'b1, ve[i]}) begin
            failures++;
            $display("FAIL sign_%0d got=%b want=%b", i,
                     {out_valid, flags()}, {1'b1, ve[i]});
         end
      end
   endtask

   task automatic test_zero_subnormal();
      logic [31:0] va [5] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0001,
                              32'h007F_FFFF, 32'h8000_0001};
      logic [31:0] vb [5] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                              32'h0080_0000, 32'h8000_0002};
      logic [3:0]  ve [5] = '{EQ, GT, LT, LT, GT};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, va[i], vb[i]);
         checks++;
         if ({out_valid, flags()} !== {1'b1, ve[i]}) begin
            failures++;
            $display("FAIL zero_sub_%0d got=%b want=%b", i,
                     {out_valid, flags()}, {1'b1, ve[i]});
         end
      end
   endtask

   task automatic test_inf_nan();
      logic [31:0] va [6] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                              32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0001};
      logic [31:0] vb [6] = '{32'h7F7F_FFFF, 32'hFF80_0000, 32'h7FC0_0000,
                              32'hFF80_0001, 32'hFF7F_FFFF, 32'h7F80_0000};
      logic [3:0]  ve [6] = '{GT, EQ, UN, UN, LT, UN};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, va[i], vb[i]);
         checks++;
         if ({out_valid, flags()} !== {1'b1, ve[i]}) begin
            failures++;
            $display("FAIL inf_nan_%0d got=%b want=%b", i,
                     {out_valid, flags()}, {1'b1, ve[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [4] = '{32'h4000_0000, 32'h3F80_0000, 32'h7FC0_0000,
                              32'hBF80_0000};
      logic [31:0] vb [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                              32'h3F80_0000};
      logic [3:0]  ve [4] = '{GT, EQ, UN, LT};
      step(1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, va[i], vb[i]);
         checks++;
         if ({out_valid, flags()} !== {1'b1, ve[i]}) begin
            failures++;
            $display("FAIL b2b_%0d got=%b want=%b", i,
                     {out_valid, flags()}, {1'b1, ve[i]});
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 32'h4000_0000, 32'h4000_0000);
         checks++;
         if ({out_valid, flags()} !== {1'b0, LT}) begin
            failures++;
            $display("FAIL hold_%0d got=%b want=%b", i,
                     {out_valid, flags()}, {1'b0, LT});
         end
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] sp [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                               32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                               32'h0000_0001, 32'h807F_FFFF, 32'h0080_0000,
                               32'h3F80_0000};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 9)];
      return $urandom;
   endfunction

   task automatic test_random();
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  e;
      for (int i = 0; i < 4000; i++) begin
         x = pick();
         y = ($urandom_range(0, 7) == 0) ? x : pick();
         if ($urandom_range(0, 9) == 0) y = x ^ 32'h0000_0001;
         e = ref_cmp(x, y);
         step(1'b1, x, y);
         checks++;
         if ({out_valid, flags()} !== {1'b1, e}) begin
            failures++;
            $display("FAIL rand a=%h b=%h got=%b want=%b", x, y,
                     {out_valid, flags()}, {1'b1, e});
         end
         checks++;
         if ($countones(flags()) != 1) begin
            failures++;
            $display("FAIL onehot a=%h b=%h got=%b want=onehot", x, y,
                     flags());
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_sign();
      test_zero_subnormal();
      test_inf_nan();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
